// File: rtl/winograd_output_tile_scheduler.sv
// Runs the 6x6->4x4 reverse transform over every tile of one output map and streams each 4x4 result, clipped, into the output buffer.
// Per tile: accept + 1 launch + RTU latency + 16 write slots; upstream is stalled (tile_ready=0) outside WAIT_TILE.
module winograd_output_tile_scheduler #(
  parameter int DATA_W  = 16,
  parameter int DIM_W   = 7,
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_valid,
  input  logic [DIM_W-1:0]                   cfg_out_h,
  input  logic [DIM_W-1:0]                   cfg_out_w,
  input  logic                               tile_valid,
  output logic                               tile_ready,
  input  logic [5:0][5:0][DATA_W-1:0]        tile_data,
  output logic                               rtu_start,
  output logic [5:0][5:0][DATA_W-1:0]        rtu_matrix_in,
  input  logic [3:0][3:0][DATA_W-1:0]        rtu_matrix_out,
  input  logic                               rtu_done,
  output logic                               wr_en,
  output logic [ADDR_W-1:0]                  wr_addr,
  output logic [DATA_W-1:0]                  wr_data,
  output logic                               busy,
  output logic                               done,
  output logic                               err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int LIN_W = 2 * DIM_W + ADDR_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TILE, S_LAUNCH, S_WAIT_DONE, S_WRITE, S_FINISH
  } state_t;

  state_t                         state_q, state_d;
  logic [DIM_W-1:0]               out_h_q, out_h_d, out_w_q, out_w_d;
  logic [DIM_W-1:0]               tiles_h_q, tiles_h_d, tiles_w_q, tiles_w_d;
  logic [DIM_W-1:0]               tile_r_q, tile_r_d, tile_c_q, tile_c_d;
  logic [3:0]                     elem_q, elem_d;
  logic [CNT_W-1:0]               tmo_q, tmo_d;
  logic [3:0][3:0][DATA_W-1:0]    result_q, result_d;
  logic [5:0][5:0][DATA_W-1:0]    mat_q, mat_d;
  logic                           tile_ready_q, tile_ready_d;
  logic                           rtu_start_q, rtu_start_d;
  logic                           wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]              wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]              wr_data_q, wr_data_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;

  logic [1:0]                     er, ec;
  logic [DIM_W+1:0]               row, col;
  logic                           in_range;
  logic [LIN_W-1:0]               lin;
  logic [DIM_W:0]                 th_w, tw_w;
  logic                           last_tile;

  // Global coordinates are tile index with the 2-bit in-tile offset appended.
  assign er        = elem_q[3:2];
  assign ec        = elem_q[1:0];
  assign row       = {tile_r_q, er};
  assign col       = {tile_c_q, ec};
  assign in_range  = (row < {2'b00, out_h_q}) && (col < {2'b00, out_w_q});
  assign lin       = LIN_W'(row) * LIN_W'(out_w_q) + LIN_W'(col);
  assign th_w      = {1'b0, cfg_out_h} + (DIM_W+1)'(3);
  assign tw_w      = {1'b0, cfg_out_w} + (DIM_W+1)'(3);
  assign last_tile = (tile_r_q == tiles_h_q - DIM_W'(1)) && (tile_c_q == tiles_w_q - DIM_W'(1));

  always_comb begin
    state_d     = state_q;
    out_h_d     = out_h_q;
    out_w_d     = out_w_q;
    tiles_h_d   = tiles_h_q;
    tiles_w_d   = tiles_w_q;
    tile_r_d    = tile_r_q;
    tile_c_d    = tile_c_q;
    elem_d      = elem_q;
    tmo_d       = tmo_q;
    result_d    = result_q;
    mat_d       = mat_q;
    rtu_start_d = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (cfg_valid && (cfg_out_h != '0) && (cfg_out_w != '0)) begin
          out_h_d   = cfg_out_h;
          out_w_d   = cfg_out_w;
          tiles_h_d = DIM_W'(th_w >> 2);
          tiles_w_d = DIM_W'(tw_w >> 2);
          tile_r_d  = '0;
          tile_c_d  = '0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_WAIT_TILE;
        end
      end
      S_WAIT_TILE: begin
        if (tile_valid && tile_ready_q) begin
          mat_d   = tile_data;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // A done level left over from the previous tile must drop before relaunching.
        if (!rtu_done) begin
          rtu_start_d = 1'b1;
          tmo_d       = '0;
          state_d     = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (rtu_done) begin
          result_d = rtu_matrix_out;
          elem_d   = '0;
          state_d  = S_WRITE;
        end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        wr_en_d = in_range;
        if (in_range) begin
          wr_addr_d = lin[ADDR_W-1:0];
          wr_data_d = result_q[er][ec];
        end
        elem_d = elem_q + 4'd1;
        if (elem_q == 4'd15) begin
          if (last_tile) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_WAIT_TILE;
            if (tile_c_q == tiles_w_q - DIM_W'(1)) begin
              tile_c_d = '0;
              tile_r_d = tile_r_q + DIM_W'(1);
            end else begin
              tile_c_d = tile_c_q + DIM_W'(1);
            end
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    tile_ready_d = (state_d == S_WAIT_TILE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      out_h_q      <= '0;
      out_w_q      <= '0;
      tiles_h_q    <= '0;
      tiles_w_q    <= '0;
      tile_r_q     <= '0;
      tile_c_q     <= '0;
      elem_q       <= '0;
      tmo_q        <= '0;
      result_q     <= '0;
      mat_q        <= '0;
      tile_ready_q <= 1'b0;
      rtu_start_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_h_q      <= out_h_d;
      out_w_q      <= out_w_d;
      tiles_h_q    <= tiles_h_d;
      tiles_w_q    <= tiles_w_d;
      tile_r_q     <= tile_r_d;
      tile_c_q     <= tile_c_d;
      elem_q       <= elem_d;
      tmo_q        <= tmo_d;
      result_q     <= result_d;
      mat_q        <= mat_d;
      tile_ready_q <= tile_ready_d;
      rtu_start_q  <= rtu_start_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign tile_ready    = tile_ready_q;
  assign rtu_start     = rtu_start_q;
  assign rtu_matrix_in = mat_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_winograd_output_tile_scheduler.sv
// Bench for winograd_output_tile_scheduler: tile source, RTU model and a write scoreboard built from the map geometry.
module tb_winograd_output_tile_scheduler;
  localparam int DATA_W = 16, DIM_W = 7, ADDR_W = 14, TIMEOUT = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst, cfg_valid, tile_valid, tile_ready, rtu_start, rtu_done;
  logic [DIM_W-1:0]            cfg_out_h, cfg_out_w;
  logic [5:0][5:0][DATA_W-1:0] tile_data, rtu_matrix_in;
  logic [3:0][3:0][DATA_W-1:0] rtu_matrix_out;
  logic                        wr_en, busy, done, err_timeout;
  logic [ADDR_W-1:0]           wr_addr;
  logic [DATA_W-1:0]           wr_data;

  winograd_output_tile_scheduler #(.DATA_W(DATA_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_out_h(cfg_out_h), .cfg_out_w(cfg_out_w),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data),
    .rtu_start(rtu_start), .rtu_matrix_in(rtu_matrix_in), .rtu_matrix_out(rtu_matrix_out), .rtu_done(rtu_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err_timeout(err_timeout));

  typedef struct { int addr; logic [15:0] data; } wr_t;
  wr_t exp_q[$];
  int  log_addr[$];
  int  log_data[$];
  int  t2_addr[$];
  int  t2_data[$];
  int  n_checks = 0, n_pass = 0;
  int  done_cnt = 0;
  logic done_prev = 1'b0;
  wr_t cur;

  int src_idx = 0, src_n = 0, cyc = 0, rtu_lat = 2;
  bit src_throttle = 0, took = 0, rtu_hang = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Inner 4x4 of tile t carries t*100 + r*4 + c; the border holds negative filler.
  function automatic logic [15:0] tval(input int t, input int r, input int c);
    if (r < 4 && c < 4) return 16'(t * 100 + r * 4 + c);
    return 16'(32'hF000 + r * 6 + c);
  endfunction

  // Scoreboard: every write must be the next expected (addr, data) pair.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        log_addr.push_back(int'(wr_addr));
        log_data.push_back(int'(wr_data));
        if (exp_q.size() == 0) chk("spurious_write", exp_q.size(), 1);
        else begin
          cur = exp_q.pop_front();
          chk("wr_addr", wr_addr, cur.addr);
          chk("wr_data", wr_data, cur.data);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_writes_left", exp_q.size(), 0);
        if (done_prev) chk("done_one_cycle", done_prev, 0);
      end
    end
    done_prev = done;
  end

  // Tile source: decides at each falling edge whether the next rising edge transfers.
  initial begin
    tile_valid = 1'b0;
    tile_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (took) src_idx++;
      tile_valid = (src_idx < src_n) && (!src_throttle || (cyc % 3 == 0));
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++)
          tile_data[r][c] = tval(src_idx, r, c);
      took = tile_valid && tile_ready;
    end
  end

  // RTU model: identity on the inner 4x4 of the held tile, one-cycle done after rtu_lat cycles.
  initial begin
    rtu_done       = 1'b0;
    rtu_matrix_out = '0;
    forever begin
      @(negedge clk);
      if (rtu_start && !rtu_hang && !rst) begin
        repeat (rtu_lat) @(negedge clk);
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            rtu_matrix_out[r][c] = rtu_matrix_in[r][c];
        rtu_done = 1'b1;
        @(negedge clk);
        rtu_done = 1'b0;
      end
    end
  end

  task automatic pulse_cfg(input int h, input int w);
    cfg_out_h = DIM_W'(h);
    cfg_out_w = DIM_W'(w);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic start_map(input int h, input int w, input bit thr, input int lat);
    int th, tw;
    wr_t e;
    th = (h + 3) / 4;
    tw = (w + 3) / 4;
    exp_q.delete();
    log_addr.delete();
    log_data.delete();
    done_cnt = 0;
    for (int tr = 0; tr < th; tr++)
      for (int tc = 0; tc < tw; tc++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            if (4*tr + r < h && 4*tc + c < w) begin
              e.addr = (4*tr + r) * w + 4*tc + c;
              e.data = tval(tr * tw + tc, r, c);
              exp_q.push_back(e);
            end
    src_idx = 0; src_n = th * tw; src_throttle = thr; rtu_lat = lat; took = 0;
    pulse_cfg(h, w);
    chk("busy_after_cfg", busy, 1);
    chk("err_after_cfg", err_timeout, 0);
  endtask

  task automatic run_map(input int h, input int w, input bit thr, input int lat, input bit inject);
    int budget;
    start_map(h, w, thr, lat);
    if (inject) begin
      repeat (3) @(negedge clk);
      pulse_cfg(8, 8);
    end
    budget = 5000;
    while (!done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("writes_left", exp_q.size(), 0);
    chk("done_count", done_cnt, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tile_ready"}, tile_ready, 0);
    chk({tag, "_rtu_start"}, rtu_start, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_rtu_in_zero"}, (rtu_matrix_in == '0), 1);
  endtask

  initial begin
    int k, mx;
    int t11[$];
    rst = 1'b1; cfg_valid = 1'b0; cfg_out_h = '0; cfg_out_w = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Zero dimension must be ignored.
    pulse_cfg(0, 5);
    chk("zero_dim_busy", busy, 0);
    repeat (2) @(negedge clk);

    // 1: single 4x4 tile.
    run_map(4, 4, 0, 2, 0);
    chk("t1_nwrites", log_addr.size(), 16);
    for (int i = 0; i < 16 && i < log_addr.size(); i++) begin
      chk("t1_addr", log_addr[i], i);
      chk("t1_data", log_data[i], i);
    end

    // 2: 6x6 map over four tiles with clipping.
    run_map(6, 6, 0, 2, 0);
    chk("t2_nwrites", log_addr.size(), 36);
    mx = 0;
    foreach (log_addr[i]) begin
      if (log_addr[i] > mx) mx = log_addr[i];
      if (log_data[i] >= 300 && log_data[i] < 316) t11.push_back(log_addr[i]);
    end
    chk("t2_max_addr", mx, 35);
    chk("t2_tile11_n", t11.size(), 4);
    if (t11.size() == 4) begin
      chk("t2_tile11_a0", t11[0], 28);
      chk("t2_tile11_a1", t11[1], 29);
      chk("t2_tile11_a2", t11[2], 34);
      chk("t2_tile11_a3", t11[3], 35);
    end
    t2_addr = log_addr;
    t2_data = log_data;

    // 3: throttled source, slow RTU: identical write stream.
    run_map(6, 6, 1, 7, 0);
    chk("t3_nwrites", log_addr.size(), t2_addr.size());
    for (int i = 0; i < log_addr.size() && i < t2_addr.size(); i++) begin
      chk("t3_addr_vs_t2", log_addr[i], t2_addr[i]);
      chk("t3_data_vs_t2", log_data[i], t2_data[i]);
    end

    // 4: RTU never answers.
    rtu_hang = 1;
    start_map(4, 4, 0, 2);
    exp_q.delete();
    k = 0;
    while (!rtu_start && k < 100) begin @(negedge clk); k++; end
    chk("t4_rtu_start_seen", rtu_start, 1);
    k = 0;
    while (!err_timeout && k < TIMEOUT + 50) begin @(negedge clk); k++; end
    chk("t4_timeout_cycles", k, TIMEOUT);
    chk("t4_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("t4_err_sticky", err_timeout, 1);
    chk("t4_no_done", done_cnt, 0);
    rtu_hang = 0;

    // 5: reset in the middle of tile 2's write phase.
    start_map(6, 6, 0, 2);
    k = 0;
    while (log_addr.size() < 26 && k < 2000) begin @(negedge clk); k++; end
    chk("t5_reached_tile2", log_addr.size(), 26);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("t5_after_rst");
    rst = 1'b0;
    src_n = 0;
    exp_q.delete();
    done_cnt = 0;
    repeat (4) @(negedge clk);
    chk("t5_idle_busy", busy, 0);
    chk("t5_no_done", done_cnt, 0);
    run_map(4, 4, 0, 3, 0);

    // 6: cfg during a running map is ignored.
    run_map(6, 6, 0, 2, 1);
    chk("t6_nwrites", log_addr.size(), 36);
    repeat (4) @(negedge clk);
    chk("t6_stays_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
